// File: rtl/note_seq_pkg.sv
// Shared types, constants and period-ROM builder for the note sequencer.
package note_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOOKUP,
        PLAY,
        GAP
    } state_t;

    typedef struct packed {
        logic        rest;
        logic [6:0]  note;
        logic [11:0] dur_ms;
    } event_t;

    localparam int EVENT_W    = $bits(event_t);
    localparam int NOTE_COUNT = 128;
    localparam int GAP_MS     = 10;

    // Equal temperament around A4 = 440 Hz (note 69), rounded to nearest cycle.
    function automatic logic [31:0] note_period(input int clk_hz, input int n);
        real freq;
        freq = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
        return 32'($rtoi(real'(clk_hz) / freq + 0.5));
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous event FIFO with occupancy count and a registered ready flag.
module note_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_n;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_n = count;
        if (do_push && !do_pop) begin
            count_n = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_n = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // ready is a register so a same-cycle pop never raises it combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_n;
            ready <= (count_n != CW'(DEPTH));
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Plays queued note events as tone periods for a PWM stage.
// Define NOTE_SEQ_GAP_EN to insert 10 ms of silence after each played event.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic [6:0]                    ev_note,
    input  logic                          ev_rest,
    input  logic [11:0]                   ev_dur_ms,
    input  logic                          run,
    output logic [31:0]                   clks_per_period,
    output logic                          new_period,
    output logic                          note_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PRESCALE = CLK_HZ / 1000;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    state_t      state;
    state_t      state_n;
    event_t      in_ev;
    event_t      head;
    event_t      cur;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [PW-1:0] pre;
    logic [11:0] ms;
    logic [11:0] limit;
    logic        tick;
    logic        expire;
    logic        timer_clr;
    logic        strobe;
    logic        strobe_tone;
    logic [31:0] rom [NOTE_COUNT];

    for (genvar i = 0; i < NOTE_COUNT; i++) begin : g_rom
        localparam logic [31:0] P = note_period(CLK_HZ, i);
        assign rom[i] = P;
    end

    assign in_ev = {ev_rest, ev_note, ev_dur_ms};
    assign push  = ev_valid && ev_ready && !fifo_full;
    assign busy  = (state != IDLE);

    note_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_ev),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .ready (ev_ready),
        .count (fifo_count)
    );

    assign limit  = (state == GAP) ? 12'(GAP_MS - 1) : cur.dur_ms - 12'd1;
    assign tick   = (pre == PRE_MAX);
    assign expire = tick && (ms == limit);

    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        note_done   = 1'b0;
        timer_clr   = 1'b0;
        strobe      = 1'b0;
        strobe_tone = 1'b0;
        unique case (state)
            IDLE: begin
                if (run && !fifo_empty) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                pop     = 1'b1;
                state_n = LOOKUP;
            end
            LOOKUP: begin
                if (cur.dur_ms == 12'd0) begin
                    note_done = 1'b1;
                    state_n   = (run && !fifo_empty) ? LOAD : IDLE;
                end else begin
                    strobe      = 1'b1;
                    strobe_tone = !cur.rest;
                    timer_clr   = 1'b1;
                    state_n     = PLAY;
                end
            end
            PLAY: begin
                if (!run) begin
                    state_n = IDLE;
                    strobe  = 1'b1;
                end else if (expire) begin
                    note_done = 1'b1;
`ifdef NOTE_SEQ_GAP_EN
                    state_n   = GAP;
                    strobe    = 1'b1;
                    timer_clr = 1'b1;
`else
                    if (!fifo_empty) begin
                        state_n = LOAD;
                    end else begin
                        state_n = IDLE;
                        strobe  = 1'b1;
                    end
`endif
                end
            end
            GAP: begin
`ifdef NOTE_SEQ_GAP_EN
                if (!run) begin
                    state_n = IDLE;
                    strobe  = 1'b1;
                end else if (expire) begin
                    if (!fifo_empty) begin
                        state_n = LOAD;
                    end else begin
                        state_n = IDLE;
                        strobe  = 1'b1;
                    end
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= '0;
        end else if (pop) begin
            cur <= head;
        end
    end

    // 1 ms prescaler feeding a millisecond counter; cleared on PLAY/GAP entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
            ms  <= '0;
        end else if (timer_clr) begin
            pre <= '0;
            ms  <= '0;
        end else if (state == PLAY || state == GAP) begin
            if (tick) begin
                pre <= '0;
                ms  <= ms + 12'd1;
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clks_per_period <= '0;
            new_period      <= 1'b0;
        end else begin
            new_period <= strobe;
            if (strobe) begin
                clks_per_period <= strobe_tone ? rom[cur.note] : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with a timeline reference model.
module tb_note_sequencer;

    localparam int CLK_HZ     = 1_000_000;
    localparam int FIFO_DEPTH = 8;
    localparam int MS         = CLK_HZ / 1000;
`ifdef NOTE_SEQ_GAP_EN
    localparam int GAP_ON  = 1;
    localparam int GAP_CYC = 10 * MS;
`else
    localparam int GAP_ON  = 0;
    localparam int GAP_CYC = 0;
`endif

    typedef struct {
        bit rest;
        int note;
        int dur;
    } tev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ev_valid = 1'b0;
    logic        ev_ready;
    logic [6:0]  ev_note = '0;
    logic        ev_rest = 1'b0;
    logic [11:0] ev_dur_ms = '0;
    logic        run = 1'b0;
    logic [31:0] clks_per_period;
    logic        new_period;
    logic        note_done;
    logic        busy;
    logic [3:0]  fifo_count;

    note_sequencer #(
        .CLK_HZ     (CLK_HZ),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ev_valid        (ev_valid),
        .ev_ready        (ev_ready),
        .ev_note         (ev_note),
        .ev_rest         (ev_rest),
        .ev_dur_ms       (ev_dur_ms),
        .run             (run),
        .clks_per_period (clks_per_period),
        .new_period      (new_period),
        .note_done       (note_done),
        .busy            (busy),
        .fifo_count      (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int st_t[$];
    int st_p[$];
    int dn_t[$];
    int stab_err = 0;
    logic [31:0] prev_p = '0;

    always @(negedge clk) begin
        if (new_period) begin
            st_t.push_back(cyc);
            st_p.push_back(int'(clks_per_period));
        end
        if (note_done) dn_t.push_back(cyc);
        if (!reset && !new_period && clks_per_period !== prev_p) stab_err++;
        prev_p = clks_per_period;
    end

    int checks = 0;
    int errors = 0;

    function automatic int ref_period(input int n);
        real f;
        f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
        return $rtoi(real'(CLK_HZ) / f + 0.5);
    endfunction

    task automatic clear_log;
        st_t.delete();
        st_p.delete();
        dn_t.delete();
    endtask

    task automatic push_ev(input bit r, input int n, input int d, output bit acc);
        ev_valid  = 1'b1;
        ev_rest   = r;
        ev_note   = 7'(n);
        ev_dur_ms = 12'(d);
        acc = ev_ready;
        @(posedge clk);
        #1 ev_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0d want 0", ev_ready); end
        checks++; if (clks_per_period !== 32'd0) begin errors++; $display("FAIL rst_period got %0d want 0", clks_per_period); end
        checks++; if (new_period !== 1'b0) begin errors++; $display("FAIL rst_strobe got %0d want 0", new_period); end
        checks++; if (note_done !== 1'b0) begin errors++; $display("FAIL rst_done got %0d want 0", note_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0d want 0", busy); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", fifo_count); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %0d want 1", ev_ready); end
    endtask

    task automatic test_single_note;
        bit acc, ok;
        int k0;
        clear_log();
        push_ev(1'b0, 69, 3, acc);
        run = 1'b1;
        k0 = cyc;
        wait_idle(20000, ok);
        run = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL single_idle got busy want idle"); end
        checks++;
        if (st_t.size() != 2 + GAP_ON || dn_t.size() != 1) begin
            errors++;
            $display("FAIL single_counts got %0d/%0d want %0d/1", st_t.size(), dn_t.size(), 2 + GAP_ON);
        end else begin
            checks++; if (st_p[0] != 2273) begin errors++; $display("FAIL single_period got %0d want 2273", st_p[0]); end
            checks++; if (st_t[0] != k0 + 3) begin errors++; $display("FAIL single_start got %0d want %0d", st_t[0], k0 + 3); end
            checks++; if (dn_t[0] != st_t[0] + 3 * MS - 1) begin errors++; $display("FAIL single_done got %0d want %0d", dn_t[0], st_t[0] + 3 * MS - 1); end
            checks++; if (st_t[1] != st_t[0] + 3 * MS || st_p[1] != 0) begin errors++; $display("FAIL single_silence got %0d@%0d want 0@%0d", st_p[1], st_t[1], st_t[0] + 3 * MS); end
            checks++; if (st_t[st_t.size()-1] != st_t[0] + 3 * MS + GAP_CYC) begin errors++; $display("FAIL single_end got %0d want %0d", st_t[st_t.size()-1], st_t[0] + 3 * MS + GAP_CYC); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %0d want 0", busy); end
    endtask

    task automatic test_fifo_full;
        bit acc, ok;
        int n_acc, k0;
        n_acc = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 7) push_ev(1'b0, $urandom_range(0, 127), 0, acc);
            else if (i == 7) push_ev(1'b0, 60, 1, acc);
            else push_ev(1'b0, 72, 1, acc);
            if (acc) n_acc++;
            if (i == 7) begin
                checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0d want 0", ev_ready); end
            end
        end
        checks++; if (n_acc != 8) begin errors++; $display("FAIL full_accepted got %0d want 8", n_acc); end
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_count got %0d want 8", fifo_count); end
        clear_log();
        run = 1'b1;
        k0 = cyc;
        wait_idle(20000, ok);
        run = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL full_idle got busy want idle"); end
        checks++;
        if (dn_t.size() != 8 || st_t.size() != 2 + GAP_ON) begin
            errors++;
            $display("FAIL full_counts got %0d/%0d want 8/%0d", dn_t.size(), st_t.size(), 2 + GAP_ON);
        end else begin
            checks++; if (dn_t[0] != k0 + 2 || dn_t[6] != k0 + 14) begin errors++; $display("FAIL full_skips got %0d,%0d want %0d,%0d", dn_t[0], dn_t[6], k0 + 2, k0 + 14); end
            checks++; if (st_t[0] != k0 + 17 || st_p[0] != 3822) begin errors++; $display("FAIL full_tone got %0d@%0d want 3822@%0d", st_p[0], st_t[0], k0 + 17); end
            checks++; if (dn_t[7] != k0 + 16 + MS) begin errors++; $display("FAIL full_last_done got %0d want %0d", dn_t[7], k0 + 16 + MS); end
        end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL full_drained got %0d want 0", fifo_count); end
    endtask

    task automatic test_back_to_back;
        bit acc, ok;
        int k0, i2;
        i2 = 1 + GAP_ON;
        clear_log();
        push_ev(1'b0, 60, 1, acc);
        push_ev(1'b0, 72, 1, acc);
        run = 1'b1;
        k0 = cyc;
        wait_idle(40000, ok);
        run = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL b2b_idle got busy want idle"); end
        checks++;
        if (st_t.size() != 3 + 2 * GAP_ON) begin
            errors++;
            $display("FAIL b2b_count got %0d want %0d", st_t.size(), 3 + 2 * GAP_ON);
        end else begin
            checks++; if (st_t[0] != k0 + 3 || st_p[0] != 3822) begin errors++; $display("FAIL b2b_first got %0d@%0d want 3822@%0d", st_p[0], st_t[0], k0 + 3); end
            checks++; if (st_p[i2] != 1911) begin errors++; $display("FAIL b2b_second got %0d want 1911", st_p[i2]); end
            checks++; if (st_t[i2] - st_t[0] != 1002 + GAP_CYC) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", st_t[i2] - st_t[0], 1002 + GAP_CYC); end
`ifdef NOTE_SEQ_GAP_EN
            checks++; if (st_t[1] != st_t[0] + MS || st_p[1] != 0) begin errors++; $display("FAIL gap_silence got %0d@%0d want 0@%0d", st_p[1], st_t[1], st_t[0] + MS); end
`endif
            checks++; if (st_p[st_p.size()-1] != 0) begin errors++; $display("FAIL b2b_end got %0d want 0", st_p[st_p.size()-1]); end
        end
    endtask

    task automatic test_rest_skip;
        bit acc, ok;
        int k0;
        clear_log();
        push_ev(1'b1, $urandom_range(0, 127), 2, acc);
        push_ev(1'b0, $urandom_range(0, 127), 0, acc);
        run = 1'b1;
        k0 = cyc;
        wait_idle(30000, ok);
        run = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL rest_idle got busy want idle"); end
        checks++;
        if (st_t.size() != 1 + GAP_ON || dn_t.size() != 2) begin
            errors++;
            $display("FAIL rest_counts got %0d/%0d want %0d/2", st_t.size(), dn_t.size(), 1 + GAP_ON);
        end else begin
            checks++; if (st_t[0] != k0 + 3 || st_p[0] != 0) begin errors++; $display("FAIL rest_strobe got %0d@%0d want 0@%0d", st_p[0], st_t[0], k0 + 3); end
            checks++; if (dn_t[0] != k0 + 2 + 2 * MS) begin errors++; $display("FAIL rest_done got %0d want %0d", dn_t[0], k0 + 2 + 2 * MS); end
            checks++; if (dn_t[1] != dn_t[0] + 2 + GAP_CYC) begin errors++; $display("FAIL skip_done got %0d want %0d", dn_t[1], dn_t[0] + 2 + GAP_CYC); end
        end
    endtask

    task automatic test_random;
        tev_t evs[$];
        int et[$], ep[$], ed[$];
        bit acc, ok, last_play;
        int k0, t, n, n_acc;
        n = GAP_ON ? 3 : 5;
        for (int trial = 0; trial < 2; trial++) begin
            evs.delete(); et.delete(); ep.delete(); ed.delete();
            n_acc = 0;
            for (int i = 0; i < n; i++) begin
                tev_t e;
                e.rest = ($urandom_range(0, 3) == 0);
                e.note = $urandom_range(0, 127);
                e.dur  = $urandom_range(0, 2);
                evs.push_back(e);
                push_ev(e.rest, e.note, e.dur, acc);
                if (acc) n_acc++;
            end
            clear_log();
            run = 1'b1;
            k0 = cyc;
            // Timeline: t is the cycle in which the next event is popped.
            t = k0 + 1;
            last_play = 1'b0;
            foreach (evs[i]) begin
                if (evs[i].dur == 0) begin
                    ed.push_back(t + 1);
                    t += 2;
                    last_play = 1'b0;
                end else begin
                    et.push_back(t + 2);
                    ep.push_back(evs[i].rest ? 0 : ref_period(evs[i].note));
                    ed.push_back(t + 1 + evs[i].dur * MS);
                    t += 2 + evs[i].dur * MS;
                    if (GAP_ON != 0) begin
                        et.push_back(t);
                        ep.push_back(0);
                        t += GAP_CYC;
                    end
                    last_play = 1'b1;
                end
            end
            if (last_play) begin
                et.push_back(t);
                ep.push_back(0);
            end
            wait_idle(40000, ok);
            run = 1'b0;
            checks++; if (n_acc != n || !ok) begin errors++; $display("FAIL rand_run got acc=%0d ok=%0d want acc=%0d ok=1", n_acc, ok, n); end
            checks++;
            if (st_t.size() != et.size()) begin
                errors++;
                $display("FAIL rand_strobes got %0d want %0d", st_t.size(), et.size());
            end else begin
                foreach (et[i]) begin
                    checks++;
                    if (st_t[i] != et[i] || st_p[i] != ep[i]) begin
                        errors++;
                        $display("FAIL rand_strobe[%0d] got %0d@%0d want %0d@%0d", i, st_p[i], st_t[i], ep[i], et[i]);
                    end
                end
            end
            checks++;
            if (dn_t.size() != ed.size()) begin
                errors++;
                $display("FAIL rand_dones got %0d want %0d", dn_t.size(), ed.size());
            end else begin
                foreach (ed[i]) begin
                    checks++;
                    if (dn_t[i] != ed[i]) begin errors++; $display("FAIL rand_done[%0d] got %0d want %0d", i, dn_t[i], ed[i]); end
                end
            end
        end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL period_stable got %0d changes want 0", stab_err); end
    endtask

    task automatic test_run_abort;
        bit acc, ok;
        int s, cnt0;
        clear_log();
        push_ev(1'b0, 64, 3, acc);
        push_ev(1'b0, 65, 2, acc);
        run = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (st_t.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_start got no strobe want strobe");
        end else begin
            s = st_t[0];
            repeat (s + 1500 - cyc) @(posedge clk);
            #1;
            cnt0 = int'(fifo_count);
            run = 1'b0;
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++; if (st_t.size() != 2) begin errors++; $display("FAIL abort_strobes got %0d want 2", st_t.size()); end
            else begin
                checks++; if (st_t[1] != s + 1501 || st_p[1] != 0) begin errors++; $display("FAIL abort_silence got %0d@%0d want 0@%0d", st_p[1], st_t[1], s + 1501); end
            end
            checks++; if (dn_t.size() != 0) begin errors++; $display("FAIL abort_done got %0d want 0", dn_t.size()); end
            checks++; if (cnt0 != 1 || int'(fifo_count) != cnt0) begin errors++; $display("FAIL abort_count got %0d/%0d want 1/1", cnt0, fifo_count); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0d want 0", busy); end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n_st;
        clear_log();
        run = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (st_t.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok || st_p.size() == 0 || st_p[0] != ref_period(65)) begin errors++; $display("FAIL mid_start got ok=%0d want tone %0d", ok, ref_period(65)); end
        repeat (500) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        checks++; if (busy !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL mid_state got busy=%0d count=%0d want 0/0", busy, fifo_count); end
        checks++; if (clks_per_period !== 32'd0 || new_period !== 1'b0) begin errors++; $display("FAIL mid_outputs got %0d/%0d want 0/0", clks_per_period, new_period); end
        checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %0d want 0", ev_ready); end
        run = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        n_st = st_t.size();
        repeat (2500) @(posedge clk);
        #1;
        checks++; if (st_t.size() != n_st || dn_t.size() != 0) begin errors++; $display("FAIL mid_quiet got %0d/%0d want %0d/0", st_t.size(), dn_t.size(), n_st); end
        checks++; if (ev_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_after got ready=%0d busy=%0d want 1/0", ev_ready, busy); end
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_fifo_full();
        test_back_to_back();
        test_rest_skip();
        test_random();
        test_run_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
